// File: rtl/instr_encoder.sv
// RV32I I/S/B instruction encoder feeding a 2-entry in-order result FIFO.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + in_opcode, in_funct3,
//   in_rd, in_rs1, in_rs2, in_imm request; out_valid/out_ready + out_instr,
//   out_err result; err_cnt saturating flagged-request count.
// Build option: define ENC_RANGE_CHECK_EN to flag out-of-range immediates
//   and count flagged requests; otherwise immediates truncate, err_cnt is 0.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_BAD
  } fmt_e;

  fmt_e        fmt;
  logic [31:0] word_i;
  logic [31:0] word_s;
  logic [31:0] word_b;
  logic        imm12_ok;
  logic        imm13_ok;
  logic [31:0] enc_word;
  logic        enc_err;

  logic [32:0] slot [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  always_comb begin
    fmt = FMT_BAD;
    case (in_opcode)
      OP_LOAD,
      OP_IMM:    fmt = FMT_I;
      OP_STORE:  fmt = FMT_S;
      OP_BRANCH: fmt = FMT_B;
      default:   fmt = FMT_BAD;
    endcase
  end

  assign word_i = {in_imm[11:0], in_rs1, in_funct3,
                   in_rd, in_opcode};
  assign word_s = {in_imm[11:5], in_rs2, in_rs1,
                   in_funct3, in_imm[4:0], in_opcode};
  assign word_b = {in_imm[12], in_imm[10:5], in_rs2,
                   in_rs1, in_funct3, in_imm[4:1],
                   in_imm[11], in_opcode};

`ifdef ENC_RANGE_CHECK_EN
  // In range iff the upper bits are a pure sign extension.
  assign imm12_ok = (in_imm[31:11] == {21{in_imm[11]}});
  assign imm13_ok = (in_imm[31:12] == {20{in_imm[12]}})
                  && !in_imm[0];
`else
  logic imm_unused;
  assign imm12_ok   = 1'b1;
  assign imm13_ok   = 1'b1;
  assign imm_unused = ^in_imm[31:13];
`endif

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    unique case (fmt)
      FMT_I: begin
        if (imm12_ok) enc_word = word_i;
        else          enc_err  = 1'b1;
      end
      FMT_S: begin
        if (imm12_ok) enc_word = word_s;
        else          enc_err  = 1'b1;
      end
      FMT_B: begin
        if (imm13_ok) enc_word = word_b;
        else          enc_err  = 1'b1;
      end
      FMT_BAD: enc_err = 1'b1;
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Outputs read as zero whenever the FIFO is empty.
  assign out_instr = out_valid ? slot[rd_ptr][31:0] : '0;
  assign out_err   = out_valid ? slot[rd_ptr][32] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= '0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= {enc_err, enc_word};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ENC_RANGE_CHECK_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (push && enc_err
                 && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Expectations follow ENC_RANGE_CHECK_EN when it is defined.
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [6:0] op,
                         input logic [2:0] f3,
                         input logic [4:0] rd,
                         input logic [4:0] rs1,
                         input logic [4:0] rs2,
                         input logic [31:0] imm);
    in_opcode = op;
    in_funct3 = f3;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push_req(input logic [6:0] op,
                          input logic [2:0] f3,
                          input logic [4:0] rd,
                          input logic [4:0] rs1,
                          input logic [4:0] rs2,
                          input logic [31:0] imm);
    int n;
    set_req(op, f3, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag,
                           input logic [31:0] exp_instr,
                           input logic exp_err);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, exp_instr);
    check({tag, "_err"}, {31'd0, out_err},
          {31'd0, exp_err});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] got_q [$];
  logic [31:0] exp_w [3];
  bit          acc;
  int          n;
  int          cyc;
  int          seen;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_req('0, '0, '0, '0, '0, '0);
    @(negedge clk);
    do_reset();

    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    // I-type, latency 1
    push_req(7'b0000011, 3'b010, 5'd5, 5'd2, 5'd9,
             32'hFFFF_FFFC);
    check("i_latency", {31'd0, out_valid}, 32'd1);
    pop_check("i_load", 32'hFFC1_2283, 1'b0);
    check("i_empty", {31'd0, out_valid}, 32'd0);

    // S- and B-type
    push_req(7'b0100011, 3'b010, 5'd31, 5'd1, 5'd6,
             32'd8);
    pop_check("s_store", 32'h0060_A423, 1'b0);
    push_req(7'b1100011, 3'b000, 5'd17, 5'd1, 5'd2,
             -32'sd8);
    pop_check("b_neg8", 32'hFE20_8CE3, 1'b0);

    // Branch upper boundary and odd offset
    push_req(7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0,
             32'd4094);
    pop_check("b_4094", 32'h7E00_0FE3, 1'b0);
    push_req(7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0,
             32'd3);
    pop_check("b_odd", RC ? 32'h0 : 32'h0000_0163, RC);
    push_req(7'b0010011, 3'b000, 5'd0, 5'd0, 5'd0,
             -32'sd2048);
    pop_check("i_m2048", 32'h8000_0013, 1'b0);

    // Backpressure: three back-to-back requests
    do_reset();
    exp_w[0] = 32'h0000_0093;
    exp_w[1] = 32'h0000_0113;
    exp_w[2] = 32'h0000_0193;
    out_ready = 1'b0;
    push_req(7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd0);
    push_req(7'b0010011, 3'b000, 5'd2, 5'd0, 5'd0, 32'd0);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    set_req(7'b0010011, 3'b000, 5'd3, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_held_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_instr", out_instr, exp_w[0]);
    out_ready = 1'b1;
    got_q.delete();
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) got_q.push_back(out_instr);
      if (in_valid && in_ready) acc = 1'b1;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_count", got_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size())
        check($sformatf("bp_word%0d", i), got_q[i],
              exp_w[i]);
      else
        check($sformatf("bp_word%0d", i), 32'hXXXX_XXXX,
              exp_w[i]);
    end

    // Error handling
    do_reset();
    push_req(7'b0010011, 3'b000, 5'd0, 5'd0, 5'd0,
             32'd2048);
    pop_check("i_2048", RC ? 32'h0 : 32'h8000_0013, RC);
    check("cnt_after_2048", {24'd0, err_cnt},
          RC ? 32'd1 : 32'd0);
    push_req(7'b0110011, 3'b000, 5'd1, 5'd2, 5'd3,
             32'd0);
    pop_check("illegal", 32'h0, 1'b1);
    check("cnt_after_illegal", {24'd0, err_cnt},
          RC ? 32'd2 : 32'd0);

    // 256 flagged requests stream through
    do_reset();
    set_req(7'b0110011, 3'b000, 5'd1, 5'd2, 5'd3, 32'd0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n   = 0;
    cyc = 0;
    while (n < 256 && cyc < 2000) begin
      if (in_ready) n++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    check("sat_accepted", n, 32'd256);
    check("sat_err_cnt", {24'd0, err_cnt},
          RC ? 32'd255 : 32'd0);

    // Reset with the FIFO full
    do_reset();
    push_req(7'b0110011, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
    push_req(7'b0010011, 3'b000, 5'd4, 5'd0, 5'd0, 32'd1);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    check("full_cnt", {24'd0, err_cnt},
          RC ? 32'd1 : 32'd0);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst2_out_instr", out_instr, 32'd0);
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("rst2_no_stale", seen, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
